// File: rtl/sensor_stream_source_pkg.sv
// rtl/sensor_stream_source_pkg.sv - shared state encoding and counter widths for the sensor stream source
package sensor_stream_source_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EMIT,
    ST_GAP_WAIT,
    ST_HOLDOFF
  } state_t;

  localparam int GAP_MAX     = 15;
  localparam int HOLDOFF_MAX = 255;
  localparam int GAP_CNT_W   = $clog2(GAP_MAX + 1);
  localparam int HOLD_CNT_W  = $clog2(HOLDOFF_MAX + 1);

  // Wide enough to hold 2^avg_log2 full-scale samples without overflow.
  function automatic int acc_width(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

endpackage

// File: rtl/sensor_stream_source_sample_averager.sv
// rtl/sensor_stream_source_sample_averager.sv - group accumulator with truncating power-of-two average
module sample_averager
  import sensor_stream_source_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic              group_done,
  output logic [DATA_W-1:0] avg
);

  localparam int ACC_W = acc_width(DATA_W, AVG_LOG2);
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;

  assign sum        = acc + ACC_W'(data);
  assign group_done = add & (cnt == LAST);
  assign avg        = DATA_W'(sum >> AVG_LOG2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear || group_done) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sensor_stream_source.sv
// rtl/sensor_stream_source.sv - paced averaging sample source with anomaly hold-off
module sensor_stream_source
  import sensor_stream_source_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int GAP      = 3,
  parameter int HOLDOFF  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              adc_ready,
  input  logic              anomaly_detected,
  output logic [DATA_W-1:0] data_input,
  output logic              data_valid,
  output logic              holdoff_active,
  output logic [15:0]       sample_count
);

  localparam logic [GAP_CNT_W-1:0]  GAP_LOAD  = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLDOFF - 1);

  state_t                state;
  logic [GAP_CNT_W-1:0]  gap_cnt;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  clear;
  logic                  add;
  logic                  group_done;
  logic [DATA_W-1:0]     avg;

  assign adc_ready = (state == ST_ACCUM);
  // A transfer coinciding with an anomaly or enable drop is taken but thrown away.
  assign clear     = adc_ready & (anomaly_detected | ~enable);
  assign add       = adc_ready & adc_valid & ~clear;

  sample_averager #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_averager (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .add       (add),
    .data      (adc_data),
    .group_done(group_done),
    .avg       (avg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      gap_cnt        <= '0;
      hold_cnt       <= '0;
      data_input     <= '0;
      data_valid     <= 1'b0;
      holdoff_active <= 1'b0;
      sample_count   <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (anomaly_detected) begin
            state          <= ST_HOLDOFF;
            hold_cnt       <= HOLD_LOAD;
            holdoff_active <= 1'b1;
          end else if (!enable) begin
            state <= ST_IDLE;
          end else if (group_done) begin
            state      <= ST_EMIT;
            data_input <= avg;
            data_valid <= 1'b1;
            if (sample_count != 16'hFFFF) sample_count <= sample_count + 16'd1;
          end
        end
        ST_EMIT: begin
          if (anomaly_detected) begin
            state          <= ST_HOLDOFF;
            hold_cnt       <= HOLD_LOAD;
            holdoff_active <= 1'b1;
          end else if (GAP > 0) begin
            state   <= ST_GAP_WAIT;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= enable ? ST_ACCUM : ST_IDLE;
          end
        end
        ST_GAP_WAIT: begin
          if (anomaly_detected) begin
            state          <= ST_HOLDOFF;
            hold_cnt       <= HOLD_LOAD;
            holdoff_active <= 1'b1;
          end else if (gap_cnt == '0) begin
            state <= enable ? ST_ACCUM : ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_CNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (anomaly_detected) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state          <= enable ? ST_ACCUM : ST_IDLE;
            holdoff_active <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_CNT_W'(1);
          end
        end
        default: begin
          state          <= ST_IDLE;
          holdoff_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_stream_source.sv
// tb/tb_sensor_stream_source.sv - directed self-checking bench for sensor_stream_source
module tb_sensor_stream_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  adc_data = 8'd0;
  logic        adc_valid = 1'b0;
  logic        adc_ready;
  logic        anomaly_detected = 1'b0;
  logic [7:0]  data_input;
  logic        data_valid;
  logic        holdoff_active;
  logic [15:0] sample_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sensor_stream_source dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .adc_data        (adc_data),
    .adc_valid       (adc_valid),
    .adc_ready       (adc_ready),
    .anomaly_detected(anomaly_detected),
    .data_input      (data_input),
    .data_valid      (data_valid),
    .holdoff_active  (holdoff_active),
    .sample_count    (sample_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic feed(input logic [7:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
  endtask

  initial begin
    int strobes;
    int last_idx;

    // Reset state
    tick();
    tick();
    chk("rst_ready", adc_ready, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_input, 0);
    chk("rst_hold", holdoff_active, 0);
    chk("rst_count", sample_count, 0);

    // Basic group 10,20,30,41 -> 25
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    chk("t1_ready", adc_ready, 1);
    feed(8'd10);
    feed(8'd20);
    feed(8'd30);
    chk("t1_no_early", data_valid, 0);
    feed(8'd41);
    adc_valid = 1'b0;
    chk("t1_valid", data_valid, 1);
    chk("t1_data", data_input, 25);
    chk("t1_count", sample_count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_gap_ready", adc_ready, 0);
      chk("t1_gap_valid", data_valid, 0);
    end
    tick();
    chk("t1_back_ready", adc_ready, 1);
    chk("t1_hold_data", data_input, 25);

    // Continuous 0xFF for 40 cycles: strobes every 8 cycles
    strobes  = 0;
    last_idx = -1;
    adc_valid = 1'b1;
    adc_data  = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_valid) begin
        chk("t2_data", data_input, 8'hFF);
        if (last_idx >= 0) chk("t2_period", i - last_idx, 8);
        last_idx = i;
        strobes++;
      end
    end
    adc_valid = 1'b0;
    chk("t2_strobes", strobes, 5);
    chk("t2_count", sample_count, 6);
    chk("t2_ready", adc_ready, 1);

    // Partial group discarded by a one-cycle anomaly
    feed(8'd100);
    feed(8'd100);
    adc_valid        = 1'b0;
    anomaly_detected = 1'b1;
    tick();
    anomaly_detected = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("t3_hold", holdoff_active, 1);
      chk("t3_hold_ready", adc_ready, 0);
      tick();
    end
    chk("t3_hold_end", holdoff_active, 0);
    chk("t3_ready_end", adc_ready, 1);
    feed(8'd4);
    feed(8'd8);
    feed(8'd12);
    feed(8'd16);
    adc_valid = 1'b0;
    chk("t3_valid", data_valid, 1);
    chk("t3_data", data_input, 10);
    chk("t3_count", sample_count, 7);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_accum", adc_ready, 1);

    // Anomaly in EMIT, re-armed at hold-off cycle 10 -> 26 cycles total
    feed(8'd50);
    feed(8'd50);
    feed(8'd50);
    feed(8'd50);
    adc_valid = 1'b0;
    chk("t4_valid", data_valid, 1);
    chk("t4_data", data_input, 50);
    anomaly_detected = 1'b1;
    tick();
    anomaly_detected = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      chk("t4_hold", holdoff_active, 1);
      chk("t4_hold_ready", adc_ready, 0);
      chk("t4_hold_valid", data_valid, 0);
      anomaly_detected = (k == 10);
      tick();
    end
    anomaly_detected = 1'b0;
    chk("t4_hold_end", holdoff_active, 0);
    chk("t4_ready_end", adc_ready, 1);
    chk("t4_count", sample_count, 8);

    // Enable drop after 3 transfers discards the partial
    feed(8'd200);
    feed(8'd200);
    feed(8'd200);
    adc_valid = 1'b0;
    enable    = 1'b0;
    tick();
    chk("t5_idle_ready", adc_ready, 0);
    chk("t5_idle_valid", data_valid, 0);
    tick();
    chk("t5_idle_ready2", adc_ready, 0);
    enable = 1'b1;
    tick();
    chk("t5_reen_ready", adc_ready, 1);
    feed(8'd8);
    feed(8'd8);
    feed(8'd8);
    feed(8'd8);
    adc_valid = 1'b0;
    chk("t5_valid", data_valid, 1);
    chk("t5_data", data_input, 8);
    chk("t5_count", sample_count, 9);

    // Asynchronous reset in GAP_WAIT
    tick();
    chk("t6_gap_ready", adc_ready, 0);
    reset = 1'b1;
    #1;
    chk("t6_rst_data", data_input, 0);
    chk("t6_rst_count", sample_count, 0);
    chk("t6_rst_valid", data_valid, 0);
    chk("t6_rst_ready", adc_ready, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_accum", adc_ready, 1);
    feed(8'd1);
    feed(8'd2);
    feed(8'd3);
    feed(8'd6);
    adc_valid = 1'b0;
    chk("t6_valid", data_valid, 1);
    chk("t6_data", data_input, 3);
    chk("t6_count", sample_count, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
